buffer4_byte_packer: RTL
========================

Name: buffer4_byte_packer

Overview:
- Upstream feeder for the 16-byte, 4-byte-write frame buffer.
- Accepts a byte stream on a valid/ready handshake and packs four bytes into one 32-bit word, first byte in the MSB.
- Writes each word into the buffer at byte index 0, 4, 8, 12, then flags the frame complete.
- While the frame is complete, hands the buffer's index port to the downstream reader; a frame_ack starts the next frame.

Parameters:
- WORDS, 4, words per frame; frame size is 4*WORDS bytes (must fit the 8-bit index).
- PAD_BYTE, 8'h00, fill value for the missing bytes of a flushed partial word.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream byte valid.
- in_data  in  8  upstream byte.
- in_ready  out  1  packer accepts a byte this cycle.
- in_last  in  1  with a valid byte: flush after this byte (pad the current word, end the frame).
- buf_write_en  out  1  one-cycle write strobe to the buffer.
- buf_index  out  8  buffer index; write address, or rd_index while in DONE.
- buf_data  out  32  packed word, {b0,b1,b2,b3}, b0 in [31:24].
- rd_index  in  8  downstream read index, forwarded to buf_index only in DONE.
- frame_done  out  1  frame fully written; buffer is readable.
- frame_ack  in  1  downstream finished reading; release the frame.
- frame_bytes  out  8  number of real (non-pad) bytes in the completed frame.

Behaviour:
- States:
  - COLLECT: accepting bytes.
  - WRITE: one-cycle write strobe.
  - DONE: frame held for the reader.
- Reset (async): state=COLLECT; byte_cnt=0, word_cnt=0, shift reg=0; frame_bytes=0.
  - Outputs at reset: in_ready=1, buf_write_en=0, buf_index=0, buf_data=0, frame_done=0.
- COLLECT:
  - in_ready=1. A byte is accepted when in_valid & in_ready.
  - The byte goes into lane byte_cnt (lane 0 = [31:24]). byte_cnt increments and frame_bytes increments.
  - On the 4th byte (byte_cnt==3), or on an accepted byte with in_last, go to WRITE next cycle. Unfilled lanes take PAD_BYTE.
  - in_last with no valid byte is ignored.
- WRITE:
  - in_ready=0, buf_write_en=1, buf_index=4*word_cnt, buf_data=packed word. Exactly one cycle.
  - Exit: if word_cnt==WORDS-1 or the word ended by in_last, go to DONE. Otherwise word_cnt++, byte_cnt=0, return to COLLECT.
  - Latency: the 4th byte is accepted in cycle N; the write strobe is in cycle N+1; the next byte can be accepted in N+2.
- DONE:
  - frame_done=1, in_ready=0, buf_write_en=0, buf_index=rd_index (combinational pass-through). frame_bytes is held.
  - On frame_ack: go to COLLECT next cycle; byte_cnt, word_cnt and frame_bytes are cleared. frame_ack outside DONE is ignored.
- buf_data holds its last value outside WRITE. Outside DONE, buf_index shows the current write address 4*word_cnt.
- in_last on the 4th byte of the last word is a normal completion; there is no extra pad write.
- Early flush: words after the flushed one are never written. The reader uses frame_bytes; buffer contents beyond frame_bytes are undefined.
- rst mid-frame or mid-WRITE: the strobe drops immediately. The partially written buffer is not cleared; the buffer's own reset is not relied on.
- The handshake must be registered-state based: no combinational path from in_valid to in_ready.

Decomposition:
- Shared package:
  - state enum {COLLECT, WRITE, DONE}.
  - BYTES_PER_WORD=4.
  - INDEX_W=8.
  - FRAME_BYTES=16 (default).
- Sub-module byte_lane_packer: 4-lane shift/insert register with a pad fill, driven by byte_cnt. The FSM and counters stay in the top.

Test Plan:
- Full frame: after reset, stream bytes 0x00..0x0F with no stalls. Required response:
  - Writes at index 0, 4, 8, 12 with data 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F.
  - frame_done=1 with frame_bytes=16.
  - in_ready is low exactly in each WRITE cycle.
- Upstream gaps: same bytes with in_valid toggling 1,0,1,0. Required: the same four writes and data; the byte stream is not corrupted.
- Flush: bytes 0xA1, 0xA2, 0xA3, 0xA4, 0xB1, then 0xB2 with in_last. Required:
  - Writes (0, 0xA1A2A3A4) and (4, 0xB1B20000).
  - DONE with frame_bytes=6; no write to index 8.
- Read/ack: in DONE, drive rd_index=5. Required: buf_index=5 in the same cycle.
  - frame_ack is followed by COLLECT, in_ready=1, frame_bytes=0.
  - The next frame writes at index 0 again.
- Reset mid-operation: assert rst during a WRITE cycle of word 2. Required:
  - buf_write_en drops immediately; all outputs go to reset values.
  - The next stream starts at index 0.
- Stray controls: frame_ack in COLLECT and in_last with in_valid=0. Required: no state change.

Source files
------------

// File: rtl/buffer4_byte_packer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// buffer4_byte_packer_pkg: shared types and constants for the byte packer
// Revision: 1.0
// ----------------------------------------------------------------------------
package buffer4_byte_packer_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int INDEX_W        = 8;
  localparam int FRAME_BYTES    = 16;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_WRITE   = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/buffer4_byte_packer_byte_lane_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// buffer4_byte_packer_byte_lane_packer: 4-lane byte insert register, pad fill
// Revision: 1.0
// ----------------------------------------------------------------------------
module buffer4_byte_packer_byte_lane_packer
  import buffer4_byte_packer_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load_i,
  input  logic [$clog2(BYTES_PER_WORD)-1:0]  lane_i,
  input  logic [7:0]                         data_i,
  output logic [8*BYTES_PER_WORD-1:0]        word_d_o
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  localparam int WORD_W = 8 * BYTES_PER_WORD;

  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_d;

  // Writing a lane pads every later lane, so a flushed word is complete as-is.
  for (genvar l = 0; l < BYTES_PER_WORD; l++) begin : g_lane
    localparam int HI = 8 * (BYTES_PER_WORD - l) - 1;
    assign word_d[HI -: 8] = (load_i && (lane_i == LANE_W'(l))) ? data_i   :
                             (load_i && (lane_i <  LANE_W'(l))) ? PAD_BYTE :
                                                                  word_q[HI -: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else if (load_i) begin
      word_q <= word_d;
    end
  end

  assign word_d_o = word_d;

endmodule
`default_nettype wire

// File: rtl/buffer4_byte_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// buffer4_byte_packer: packs a byte stream into 32-bit frame-buffer words
// Revision: 1.0
// ----------------------------------------------------------------------------
module buffer4_byte_packer
  import buffer4_byte_packer_pkg::*;
#(
  parameter int         WORDS    = FRAME_BYTES / BYTES_PER_WORD,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid_i,
  input  logic [7:0]                  in_data_i,
  output logic                        in_ready_o,
  input  logic                        in_last_i,
  output logic                        buf_write_en_o,
  output logic [INDEX_W-1:0]          buf_index_o,
  output logic [8*BYTES_PER_WORD-1:0] buf_data_o,
  input  logic [INDEX_W-1:0]          rd_index_i,
  output logic                        frame_done_o,
  input  logic                        frame_ack_i,
  output logic [INDEX_W-1:0]          frame_bytes_o
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WORD_W = 8 * BYTES_PER_WORD;

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   byte_cnt_q;
  logic [WCNT_W-1:0]   word_cnt_q;
  logic [INDEX_W-1:0]  frame_bytes_q;
  logic                last_q;
  logic [WORD_W-1:0]   buf_data_q;
  logic [WORD_W-1:0]   word_d;
  logic [INDEX_W-1:0]  wr_index;
  logic                accept;
  logic                word_end;
  logic                last_word;

  assign accept    = in_valid_i && (state_q == ST_COLLECT);
  assign word_end  = accept && ((byte_cnt_q == LANE_W'(BYTES_PER_WORD - 1)) || in_last_i);
  assign last_word = (word_cnt_q == WCNT_W'(WORDS - 1));
  assign wr_index  = {{(INDEX_W - WCNT_W - LANE_W){1'b0}}, word_cnt_q, {LANE_W{1'b0}}};

  buffer4_byte_packer_byte_lane_packer #(
    .PAD_BYTE (PAD_BYTE)
  ) u_lanes (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept),
    .lane_i   (byte_cnt_q),
    .data_i   (in_data_i),
    .word_d_o (word_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (word_end) state_d = ST_WRITE;
      ST_WRITE:   state_d = (last_word || last_q) ? ST_DONE : ST_COLLECT;
      ST_DONE:    if (frame_ack_i) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  always_comb begin
    in_ready_o     = (state_q == ST_COLLECT);
    buf_write_en_o = (state_q == ST_WRITE);
    frame_done_o   = (state_q == ST_DONE);
    buf_index_o    = (state_q == ST_DONE) ? rd_index_i : wr_index;
  end

  // The packed word is latched as the word closes and held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q    <= '0;
      word_cnt_q    <= '0;
      frame_bytes_q <= '0;
      last_q        <= 1'b0;
      buf_data_q    <= '0;
    end else begin
      if (accept) begin
        frame_bytes_q <= frame_bytes_q + INDEX_W'(1);
        byte_cnt_q    <= word_end ? '0 : byte_cnt_q + LANE_W'(1);
        last_q        <= in_last_i;
        if (word_end) buf_data_q <= word_d;
      end
      if ((state_q == ST_WRITE) && (state_d == ST_COLLECT)) begin
        word_cnt_q <= word_cnt_q + WCNT_W'(1);
      end
      if ((state_q == ST_DONE) && frame_ack_i) begin
        byte_cnt_q    <= '0;
        word_cnt_q    <= '0;
        frame_bytes_q <= '0;
        last_q        <= 1'b0;
      end
    end
  end

  assign buf_data_o    = buf_data_q;
  assign frame_bytes_o = frame_bytes_q;

endmodule
`default_nettype wire
